// File: rtl/iccm_ecc_scrub.sv
// ---------------------------------------------------------------------------
// iccm_ecc_scrub
//
// Purpose:
//   Watches ICCM ECC decoder results. A correctable (single-bit) error is
//   scrubbed by writing the corrected word and ECC back to the ICCM through
//   the arbiter. Uncorrectable and address errors are never written back.
//   Instead they raise a one-cycle interrupt pulse and set a sticky status
//   flag that records the address of the first such error.
//
// Optional feature:
//   ICCM_ECC_SB_CNT_EN - when defined, a saturating correctable-error counter
//                        is built and drives sb_err_cnt. When undefined, no
//                        counter flops exist and sb_err_cnt is tied to zero.
//
// Ports:
//   clk            in   sole clock, rising edge
//   rst_a          in   synchronous active-high reset (highest priority)
//   chk_valid      in   decoder result valid strobe
//   chk_addr       in   [ADDR_W] word address of the checked read
//   chk_data       in   [32] corrected data
//   chk_ecc        in   [8]  corrected ECC
//   chk_sb_err     in   correctable-error flag
//   chk_db_err     in   uncorrectable-error flag
//   chk_addr_err   in   address-error flag
//   wb_req         out  write-back request to the ICCM arbiter
//   wb_addr        out  [ADDR_W] write-back address
//   wb_data        out  [32] write-back data
//   wb_ecc         out  [8]  write-back ECC
//   wb_ack         in   arbiter accepts the write-back
//   scrub_busy     out  write-back pending
//   db_err_status  out  sticky uncorrectable/address-error flag
//   db_err_addr    out  [ADDR_W] address of the first uncorrectable error
//   sb_drop        out  sticky flag: a correctable error was not scrubbed
//   err_irq        out  one-cycle pulse per uncorrectable/address error
//   status_clr     in   clears db_err_status, sb_drop and the counter
//   sb_err_cnt     out  [CNT_W] correctable-error count
// ---------------------------------------------------------------------------
module iccm_ecc_scrub #(
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_a,

    input  logic              chk_valid,
    input  logic [ADDR_W-1:0] chk_addr,
    input  logic [31:0]       chk_data,
    input  logic [7:0]        chk_ecc,
    input  logic              chk_sb_err,
    input  logic              chk_db_err,
    input  logic              chk_addr_err,

    output logic              wb_req,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [31:0]       wb_data,
    output logic [7:0]        wb_ecc,
    input  logic              wb_ack,

    output logic              scrub_busy,
    output logic              db_err_status,
    output logic [ADDR_W-1:0] db_err_addr,
    output logic              sb_drop,
    output logic              err_irq,
    input  logic              status_clr,
    output logic [CNT_W-1:0]  sb_err_cnt
);

    // -----------------------------------------------------------------------
    // FSM encoding
    // -----------------------------------------------------------------------
    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_WB_REQ = 1'b1;

    // -----------------------------------------------------------------------
    // Event decode
    // -----------------------------------------------------------------------
    logic sb_ev;
    logic hard_ev;

    // A result that also carries a hard error is not scrubbable, so the
    // correctable flag only counts when no hard flag accompanies it.
    assign sb_ev   = chk_valid & chk_sb_err & ~chk_db_err & ~chk_addr_err;
    assign hard_ev = chk_valid & (chk_db_err | chk_addr_err);

    // -----------------------------------------------------------------------
    // State and payload registers
    // -----------------------------------------------------------------------
    logic              state_q,         state_d;
    logic [ADDR_W-1:0] pl_addr_q,       pl_addr_d;
    logic [31:0]       pl_data_q,       pl_data_d;
    logic [7:0]        pl_ecc_q,        pl_ecc_d;
    logic              db_err_status_q, db_err_status_d;
    logic [ADDR_W-1:0] db_err_addr_q,   db_err_addr_d;
    logic              sb_drop_q,       sb_drop_d;
    logic              err_irq_q,       err_irq_d;

    logic capture;
    logic drop;

    // Only an idle scrubber accepts a new correctable error. Anything seen
    // while a write-back is pending, including on the transfer cycle itself,
    // is dropped.
    assign capture = sb_ev & (state_q == ST_IDLE);
    assign drop    = sb_ev & (state_q == ST_WB_REQ);

    always_comb begin
        state_d   = state_q;
        pl_addr_d = pl_addr_q;
        pl_data_d = pl_data_q;
        pl_ecc_d  = pl_ecc_q;

        case (state_q)
            ST_IDLE: begin
                if (capture) begin
                    pl_addr_d = chk_addr;
                    pl_data_d = chk_data;
                    pl_ecc_d  = chk_ecc;
                    state_d   = ST_WB_REQ;
                end
            end
            ST_WB_REQ: begin
                if (wb_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Status logic
    // -----------------------------------------------------------------------
    always_comb begin
        db_err_status_d = db_err_status_q;
        db_err_addr_d   = db_err_addr_q;
        sb_drop_d       = sb_drop_q;
        err_irq_d       = hard_ev;

        // Set takes priority over clear. A clear in the same cycle as a hard
        // error also frees the address slot, so the new address is recorded.
        if (status_clr) begin
            db_err_status_d = 1'b0;
            sb_drop_d       = 1'b0;
        end
        if (hard_ev) begin
            db_err_status_d = 1'b1;
            if (!db_err_status_q || status_clr) begin
                db_err_addr_d = chk_addr;
            end
        end
        if (drop) begin
            sb_drop_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_a) begin
            state_q         <= ST_IDLE;
            pl_addr_q       <= '0;
            pl_data_q       <= '0;
            pl_ecc_q        <= '0;
            db_err_status_q <= 1'b0;
            db_err_addr_q   <= '0;
            sb_drop_q       <= 1'b0;
            err_irq_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            pl_addr_q       <= pl_addr_d;
            pl_data_q       <= pl_data_d;
            pl_ecc_q        <= pl_ecc_d;
            db_err_status_q <= db_err_status_d;
            db_err_addr_q   <= db_err_addr_d;
            sb_drop_q       <= sb_drop_d;
            err_irq_q       <= err_irq_d;
        end
    end

    // -----------------------------------------------------------------------
    // Optional correctable-error counter
    // -----------------------------------------------------------------------
`ifdef ICCM_ECC_SB_CNT_EN
    logic [CNT_W-1:0] sb_cnt_q, sb_cnt_d;

    // Clear and increment in the same cycle leaves the count at one.
    always_comb begin
        sb_cnt_d = sb_cnt_q;
        if (status_clr) begin
            sb_cnt_d = '0;
        end
        if (sb_ev && (sb_cnt_d != '1)) begin
            sb_cnt_d = sb_cnt_d + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_a) begin
            sb_cnt_q <= '0;
        end else begin
            sb_cnt_q <= sb_cnt_d;
        end
    end

    assign sb_err_cnt = sb_cnt_q;
`else
    assign sb_err_cnt = '0;
`endif

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign wb_req        = (state_q == ST_WB_REQ);
    assign scrub_busy    = (state_q == ST_WB_REQ);
    assign wb_addr       = pl_addr_q;
    assign wb_data       = pl_data_q;
    assign wb_ecc        = pl_ecc_q;
    assign db_err_status = db_err_status_q;
    assign db_err_addr   = db_err_addr_q;
    assign sb_drop       = sb_drop_q;
    assign err_irq       = err_irq_q;

endmodule

// File: doc/iccm_ecc_scrub.md
ICCM_ECC_SCRUB -- requirements
Module: iccm_ecc_scrub

Interface
REQ-001 Parameter ADDR_W, default 17, ICCM word-address width.
REQ-002 Parameter CNT_W, default 8, single-bit error counter width.
REQ-003 clk  in  1  sole clock; all state SHALL update on rising edge.
REQ-004 rst_a  in  1  reset, synchronous, active-high.
REQ-005 chk_valid  in  1  one-cycle strobe: decoder result valid.
REQ-006 chk_addr  in  ADDR_W  word address of checked read.
REQ-007 chk_data  in  32  corrected data from decoder.
REQ-008 chk_ecc  in  8  corrected ECC from decoder.
REQ-009 chk_sb_err / chk_db_err / chk_addr_err  in  1 each  decoder error flags.
REQ-010 wb_req  out  1  scrub write-back request to ICCM arbiter.
REQ-011 wb_addr / wb_data / wb_ecc  out  ADDR_W / 32 / 8  write-back payload.
REQ-012 wb_ack  in  1  arbiter accepts write-back.
REQ-013 scrub_busy  out  1  write-back pending.
REQ-014 db_err_status  out  1  sticky uncorrectable-error flag.
REQ-015 db_err_addr  out  ADDR_W  address of first uncorrectable error.
REQ-016 sb_drop  out  1  sticky flag: correctable error not scrubbed (busy).
REQ-017 err_irq  out  1  one-cycle pulse per uncorrectable/address error.
REQ-018 status_clr  in  1  clears db_err_status, sb_drop, counter.
REQ-019 sb_err_cnt  out  CNT_W  correctable-error count (see Configuration).

Function
REQ-020 FSM states SHALL be IDLE and WB_REQ only.
REQ-021 "sb event" = chk_valid & chk_sb_err & !chk_db_err & !chk_addr_err; "hard event" = chk_valid & (chk_db_err | chk_addr_err).
REQ-022 IDLE + sb event: capture chk_addr/chk_data/chk_ecc into payload register, go WB_REQ; wb_req high the next cycle (latency 1).
REQ-023 WB_REQ: wb_req SHALL stay high and payload SHALL stay stable until wb_ack sampled high; transfer occurs on the cycle wb_req & wb_ack.
REQ-024 On transfer: go IDLE; wb_req low the following cycle; a new sb event on the transfer cycle SHALL NOT be captured (dropped, sb_drop set).
REQ-025 sb event while in WB_REQ: SHALL be dropped, sb_drop set, payload unchanged.
REQ-026 wb_ack while wb_req low SHALL be ignored.
REQ-027 scrub_busy SHALL equal (state == WB_REQ).
REQ-028 Hard event: err_irq high next cycle for exactly one cycle; db_err_status set; db_err_addr loaded only if db_err_status was clear (first error held).
REQ-029 Hard events SHALL never trigger a write-back and SHALL not affect FSM state.
REQ-030 status_clr and hard event same cycle: set wins; db_err_addr loads new address.
REQ-031 status_clr and sb_drop-setting event same cycle: set wins.
REQ-032 wb_data/wb_ecc/wb_addr SHALL be driven from payload register in all states (no gating).

Reset
REQ-033 rst_a high at a clock edge: state IDLE; wb_req, scrub_busy, db_err_status, sb_drop, err_irq = 0; db_err_addr, payload, sb_err_cnt = 0.
REQ-034 Reset mid-WB_REQ SHALL abandon the pending write-back with no further request.
REQ-035 rst_a has priority over all inputs including status_clr.

Configuration
REQ-036 Macro ICCM_ECC_SB_CNT_EN: defined -> sb_err_cnt increments by 1 on every sb event (captured or dropped), saturates at all-ones, clears on status_clr (clear then increment same cycle yields 1).
REQ-037 ICCM_ECC_SB_CNT_EN undefined -> no counter flops; sb_err_cnt tied to 0; port retained.

Verification
REQ-038 sb event addr=0x00010, data=0xDEADBEEF, ecc=0x5A; wb_ack after 3 cycles -> wb_req high 3 cycles, payload stable, scrub_busy clears, wb_req low next cycle.
REQ-039 Second sb event addr=0x00020 while WB_REQ -> sb_drop=1, wb_addr stays 0x00010, count=2 (macro on).
REQ-040 db event addr=0x00100 then addr_err event addr=0x00200 -> two err_irq pulses, db_err_status=1, db_err_addr=0x00100, wb_req never asserted.
REQ-041 status_clr with simultaneous db event addr=0x00300 -> db_err_status=1, db_err_addr=0x00300.
REQ-042 256 sb events, CNT_W=8, macro on -> sb_err_cnt=0xFF; macro off -> 0.
REQ-043 rst_a asserted during WB_REQ -> wb_req=0 next cycle, all status 0, no later request.
